// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM:
// opcodes, state codes, ALU/mux select codes and the decoded control vector.
package mips_mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_EXECUTE = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JUMP    = 4'd12
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // wait_mem marks states whose strobes are qualified by mem_ready.
   typedef struct packed {
      logic       mem_req;
      logic       iord;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       branch;
      logic       wait_mem;
   } ctrl_t;

   function automatic logic op_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the control FSM and memory.
interface mips_multicycle_ctrl_if;
   logic mem_req;
   logic mem_ready;
   logic iord;
   logic memwrite;

   modport master (output mem_req, output iord, output memwrite, input mem_ready);
   modport slave  (input mem_req, input iord, input memwrite, output mem_ready);
endinterface

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Pure state-to-control-vector decoder; unlisted fields and unused codes give 0.
module mips_mc_outdec
   import mips_mc_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req  = 1'b1;
            ctrl.alusrcb  = SRCB_FOUR;
            ctrl.aluop    = ALUOP_ADD;
            ctrl.pcsrc    = PC_ALU;
            ctrl.irwrite  = 1'b1;
            ctrl.pcwrite  = 1'b1;
            ctrl.wait_mem = 1'b1;
         end
         // Branch target is precomputed here while the opcode is examined.
         S_DECODE: begin
            ctrl.alusrcb = SRCB_IMMSH;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_req  = 1'b1;
            ctrl.iord     = 1'b1;
            ctrl.wait_mem = 1'b1;
         end
         S_MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_req  = 1'b1;
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.wait_mem = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_RT;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_RT;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PC_ALUOUT;
            ctrl.branch  = 1'b1;
         end
         S_ADDIWB: ctrl.regwrite = 1'b1;
         S_JUMP: begin
            ctrl.pcsrc   = PC_JUMP;
            ctrl.pcwrite = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: state register, next-state
// logic and the mem_ready / zero / opcode dependent output glue.
module mips_multicycle_ctrl
   import mips_mc_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [5:0]              opcode,
   input  logic                    zero,
   mips_multicycle_ctrl_if.master  mem,
   output logic                    irwrite,
   output logic                    regwrite,
   output logic                    regdst,
   output logic                    memtoreg,
   output logic                    alusrca,
   output logic [1:0]              alusrcb,
   output logic [1:0]              aluop,
   output logic [1:0]              pcsrc,
   output logic                    pcen,
   output logic                    illegal_op
);

   logic [STATE_W-1:0] state_reg;
   ctrl_t              ctrl;
   logic               strobe_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         case (state_reg)
            S_IDLE:   state_reg <= S_FETCH;
            S_FETCH:  if (mem.mem_ready) state_reg <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: state_reg <= S_MEMADR;
                  OP_RTYPE:     state_reg <= S_EXECUTE;
                  OP_BEQ:       state_reg <= S_BRANCH;
                  OP_ADDI:      state_reg <= S_ADDIEX;
                  OP_J:         state_reg <= S_JUMP;
                  default:      state_reg <= S_FETCH;
               endcase
            end
            // The IR holds the opcode stable, so it still selects load vs store.
            S_MEMADR:  state_reg <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem.mem_ready) state_reg <= S_MEMWB;
            S_MEMWR:   if (mem.mem_ready) state_reg <= S_FETCH;
            S_EXECUTE: state_reg <= S_ALUWB;
            S_ADDIEX:  state_reg <= S_ADDIWB;
            default:   state_reg <= S_FETCH;
         endcase
      end
   end

   mips_mc_outdec u_outdec (
      .state (state_t'(state_reg)),
      .ctrl  (ctrl)
   );

   // Memory-side strobes fire only in the cycle the access completes.
   assign strobe_ok    = ~ctrl.wait_mem | mem.mem_ready;

   assign mem.mem_req  = ctrl.mem_req;
   assign mem.iord     = ctrl.iord;
   assign mem.memwrite = ctrl.memwrite & strobe_ok;
   assign irwrite      = ctrl.irwrite & strobe_ok;
   assign regwrite     = ctrl.regwrite;
   assign regdst       = ctrl.regdst;
   assign memtoreg     = ctrl.memtoreg;
   assign alusrca      = ctrl.alusrca;
   assign alusrcb      = ctrl.alusrcb;
   assign aluop        = ctrl.aluop;
   assign pcsrc        = ctrl.pcsrc;
   assign pcen         = (ctrl.pcwrite & strobe_ok) | (ctrl.branch & zero);
   assign illegal_op   = (state_reg == S_DECODE) && !op_legal(opcode);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS control FSM; one check per cycle.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       irwrite, regwrite, regdst, memtoreg, alusrca, pcen, illegal_op;
   logic [1:0] alusrcb, aluop, pcsrc;
   int         errors = 0;
   int         checks = 0;

   mips_multicycle_ctrl_if mem ();

   mips_multicycle_ctrl #(.STATE_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem        (mem),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .aluop      (aluop),
      .pcsrc      (pcsrc),
      .pcen       (pcen),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   // {mem_req,iord,memwrite,irwrite, regwrite,regdst,memtoreg,alusrca,
   //  alusrcb,aluop, pcsrc,pcen,illegal_op}
   logic [15:0] obs;
   assign obs = {mem.mem_req, mem.iord, mem.memwrite, irwrite,
                 regwrite, regdst, memtoreg, alusrca,
                 alusrcb, aluop, pcsrc, pcen, illegal_op};

   localparam logic [15:0] E_IDLE    = 16'b0000_0000_0000_0000;
   localparam logic [15:0] E_FETCH   = 16'b1001_0000_0100_0010;
   localparam logic [15:0] E_FETCHW  = 16'b1000_0000_0100_0000;
   localparam logic [15:0] E_DECODE  = 16'b0000_0000_1100_0000;
   localparam logic [15:0] E_DECILL  = 16'b0000_0000_1100_0001;
   localparam logic [15:0] E_MEMADR  = 16'b0000_0001_1000_0000;
   localparam logic [15:0] E_MEMRD   = 16'b1100_0000_0000_0000;
   localparam logic [15:0] E_MEMWB   = 16'b0000_1010_0000_0000;
   localparam logic [15:0] E_MEMWRW  = 16'b1100_0000_0000_0000;
   localparam logic [15:0] E_MEMWR   = 16'b1110_0000_0000_0000;
   localparam logic [15:0] E_EXEC    = 16'b0000_0001_0010_0000;
   localparam logic [15:0] E_ALUWB   = 16'b0000_1100_0000_0000;
   localparam logic [15:0] E_BRZ1    = 16'b0000_0001_0001_0110;
   localparam logic [15:0] E_BRZ0    = 16'b0000_0001_0001_0100;
   localparam logic [15:0] E_ADDIWB  = 16'b0000_1000_0000_0000;
   localparam logic [15:0] E_JUMP    = 16'b0000_0000_0000_1010;

   task automatic check(input string tag, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
      end
      checks++;
      assert ($countones({regwrite, mem.memwrite, irwrite}) <= 1 &&
              !(mem.memwrite && !mem.mem_ready)) else begin
         errors++;
         $error("FAIL %s_excl: rw/mw/ir=%b%b%b mem_ready=%b", tag,
                regwrite, mem.memwrite, irwrite, mem.mem_ready);
      end
   endtask

   // Sample at the falling edge, then advance past the next rising edge.
   task automatic cyc(input string tag, input logic [15:0] expv);
      @(negedge clk);
      check(tag, expv);
      $display("cycle %-10s obs=%b exp=%b", tag, obs, expv);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      opcode = 6'b000000;
      zero = 1'b0;
      mem.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cyc("rst_hold", E_IDLE);
      rst_n = 1'b1;
      cyc("idle", E_IDLE);

      // R-type, then a FETCH stall of one cycle.
      cyc("r_fetch", E_FETCH);
      cyc("r_decode", E_DECODE);
      cyc("r_exec", E_EXEC);
      cyc("r_aluwb", E_ALUWB);
      mem.mem_ready = 1'b0;
      opcode = 6'b100011;
      cyc("lw_fetchw", E_FETCHW);
      mem.mem_ready = 1'b1;

      // lw with MEMRD held for three cycles.
      cyc("lw_fetch", E_FETCH);
      cyc("lw_decode", E_DECODE);
      cyc("lw_memadr", E_MEMADR);
      mem.mem_ready = 1'b0;
      cyc("lw_memrd0", E_MEMRD);
      cyc("lw_memrd1", E_MEMRD);
      mem.mem_ready = 1'b1;
      cyc("lw_memrd2", E_MEMRD);
      cyc("lw_memwb", E_MEMWB);

      // beq taken, then not taken.
      opcode = 6'b000100;
      zero = 1'b1;
      cyc("beq1_fetch", E_FETCH);
      cyc("beq1_decode", E_DECODE);
      cyc("beq1_branch", E_BRZ1);
      cyc("beq0_fetch", E_FETCH);
      cyc("beq0_decode", E_DECODE);
      zero = 1'b0;
      cyc("beq0_branch", E_BRZ0);

      // Illegal opcode, twice back to back.
      opcode = 6'b111111;
      cyc("ill_fetch", E_FETCH);
      cyc("ill_decode", E_DECILL);
      cyc("ill_fetch2", E_FETCH);
      cyc("ill_decode2", E_DECILL);

      // sw with one stall cycle in MEMWR.
      opcode = 6'b101011;
      cyc("sw_fetch", E_FETCH);
      cyc("sw_decode", E_DECODE);
      cyc("sw_memadr", E_MEMADR);
      mem.mem_ready = 1'b0;
      cyc("sw_memwr0", E_MEMWRW);
      mem.mem_ready = 1'b1;
      cyc("sw_memwr1", E_MEMWR);

      // addi and j.
      opcode = 6'b001000;
      cyc("addi_fetch", E_FETCH);
      cyc("addi_decode", E_DECODE);
      cyc("addi_ex", E_MEMADR);
      cyc("addi_wb", E_ADDIWB);
      opcode = 6'b000010;
      cyc("j_fetch", E_FETCH);
      cyc("j_decode", E_DECODE);
      cyc("j_jump", E_JUMP);

      // Asynchronous reset in the middle of a stalled store.
      opcode = 6'b101011;
      cyc("rsw_fetch", E_FETCH);
      cyc("rsw_decode", E_DECODE);
      cyc("rsw_memadr", E_MEMADR);
      mem.mem_ready = 1'b0;
      cyc("rsw_memwr0", E_MEMWRW);
      rst_n = 1'b0;
      #1;
      check("rst_async", E_IDLE);
      $display("cycle %-10s obs=%b exp=%b", "rst_async", obs, E_IDLE);
      mem.mem_ready = 1'b1;
      cyc("rst_low", E_IDLE);
      rst_n = 1'b1;
      cyc("rst_idle", E_IDLE);
      cyc("rst_fetch", E_FETCH);
      cyc("rst_decode", E_DECODE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS variant of the core. Sequences each instruction through fetch, decode, execute, memory and writeback steps. Drives datapath enables and muxes, and drives the 2-bit aluop consumed by the ALU decoder (00 add, 01 subtract, 10 use funct). Handshakes with a single shared instruction/data memory through mem_req/mem_ready.

Parameters:
- STATE_W, 4, width of the state register.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- opcode, input, 6, instr[31:26] from the instruction register.
- zero, input, 1, ALU zero flag.
- mem_ready, input, 1, memory has completed the current access this cycle.
- mem_req, output, 1, memory access request.
- iord, output, 1, memory address select: 0 = PC, 1 = ALUOut.
- memwrite, output, 1, memory write strobe.
- irwrite, output, 1, instruction register load.
- regwrite, output, 1, register file write.
- regdst, output, 1, destination register select: 1 = rd, 0 = rt.
- memtoreg, output, 1, writeback data select: 1 = memory data, 0 = ALUOut.
- alusrca, output, 1, ALU A select: 0 = PC, 1 = rs.
- alusrcb, output, 2, ALU B select: 00 rt, 01 const 4, 10 sign-extended immediate, 11 immediate<<2.
- aluop, output, 2, ALU operation class sent to the ALU decoder.
- pcsrc, output, 2, next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
- pcen, output, 1, PC load; equals pcwrite | (branch & zero).
- illegal_op, output, 1, unsupported opcode seen in DECODE.

Behaviour:
- Moore FSM with a registered state. All outputs are decoded combinationally from state, except:
  - pcen uses zero;
  - FETCH, MEMRD and MEMWR gate their strobes with mem_ready;
  - illegal_op uses opcode.
- Any output not listed for a state is 0. Default selects are 0.
- Reset:
  - rst_n low forces state IDLE asynchronously, so every output reads 0.
  - IDLE is exited to FETCH on the first clock edge after reset is released.
  - Reset mid-instruction abandons the instruction; no partial write follows.
- States, outputs and transitions:
  - IDLE: all outputs 0 -> FETCH.
  - FETCH: mem_req=1, iord=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=pcen=mem_ready. Stays in FETCH while mem_ready=0; on mem_ready=1 -> DECODE.
  - DECODE: alusrcb=11, aluop=00 (branch target precompute).
    - opcode 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode: illegal_op=1 for this cycle, -> FETCH, no write occurs.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD, sw -> MEMWR (uses opcode, held stable by IR).
  - MEMRD: mem_req=1, iord=1. Waits for mem_ready, then -> MEMWB.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
  - MEMWR: mem_req=1, iord=1, memwrite=mem_ready. Waits for mem_ready, then -> FETCH. memwrite is never asserted without mem_ready.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, so pcen=zero -> FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
  - JUMP: pcsrc=10, pcen=1 -> FETCH.
- Unused state encodings: recover to FETCH on the next edge with all outputs 0.
- Latency with mem_ready tied high: R-type 4 cycles, lw 5, sw 4, addi 4, beq 3, j 3. Each cycle mem_ready is low adds one cycle in FETCH, MEMRD or MEMWR.
- At most one of regwrite, memwrite and irwrite is high in any cycle.

Decomposition:
- Shared package mips_mc_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - state encodings (S_IDLE through S_JUMP);
  - aluop codes (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - alusrcb and pcsrc select encodings.
- One natural sub-module: mips_mc_outdec, the pure combinational state-to-control-vector decoder. The top module keeps the state register, the next-state logic, and the pcen/illegal_op glue.

Test Plan:
1. Reset: rst_n low mid-MEMWR with mem_ready=0 -> all outputs 0 immediately. After release: IDLE for 1 cycle, then FETCH with mem_req=1, and memwrite never pulses.
2. R-type, opcode 000000, mem_ready=1 -> FETCH/DECODE/EXECUTE/ALUWB. aluop=10 only in EXECUTE. regwrite=1, regdst=1 in cycle 4. Back in FETCH in cycle 5.
3. lw with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles with iord=1. Then MEMWB with regwrite=1, memtoreg=1. Total 7 cycles.
4. beq twice: zero=1 in BRANCH -> pcen=1, pcsrc=01, aluop=01. Repeat with zero=0 -> pcen=0. Both cases 3 cycles.
5. Illegal opcode 111111 -> illegal_op=1 for exactly the DECODE cycle, then FETCH. regwrite, memwrite and pcen stay 0 after FETCH.
6. sw with mem_ready=0 for 1 cycle -> memwrite=0 in the first MEMWR cycle, memwrite=1 in the second. Then FETCH.
